// File: rtl/ro_scan_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ro_scan_meter
// Brief    : Scanning multi-channel ring-oscillator frequency meter with
//            settle delay, gated edge counting and per-channel averaging.
// Revision : 1.0  initial release
// ============================================================================
module ro_scan_meter #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 16,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 16,
    localparam int c_ch_w    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              cont,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [NCH-1:0]    ro_in,
    output logic [NCH-1:0]    ro_en,
    output logic [CNT_W-1:0]  result,
    output logic [c_ch_w-1:0] result_ch,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int c_acc_w = CNT_W + AVG_LOG2;
    localparam int c_win_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_set_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_nwin  = 1 << AVG_LOG2;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [NCH-1:0]      r_sync1, r_sync2, r_prev;
    logic [NCH-1:0]      r_mask;
    logic [GATE_W-1:0]   r_gate, r_gate_cnt;
    logic [c_ch_w-1:0]   r_ch;
    logic [c_set_w-1:0]  r_settle_cnt;
    logic [c_win_w-1:0]  r_win;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_acc_w-1:0]  r_acc;
    logic [CNT_W-1:0]    r_result;
    logic [c_ch_w-1:0]   r_result_ch;
    logic                r_overflow;

    logic [NCH-1:0]      w_edge_vec;
    logic                w_edge;
    logic [GATE_W-1:0]   w_gate_eff;
    logic                w_settle_done, w_gate_last, w_win_last;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [c_acc_w-1:0]  w_acc_next;
    logic [c_ch_w:0]     w_next_sel, w_wrap_sel;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [c_ch_w:0] f_first_set(input logic [NCH-1:0] mask, input int from);
        logic [c_ch_w:0] sel;
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) sel = {1'b1, c_ch_w'(i)};
        end
        return sel;
    endfunction

    assign w_edge_vec    = r_sync2 & ~r_prev;
    assign w_edge        = w_edge_vec[r_ch];
    assign w_gate_eff    = (gate_len == '0) ? GATE_W'(1) : gate_len;
    assign w_settle_done = (r_settle_cnt == c_set_w'(SETTLE_CYC - 1));
    assign w_gate_last   = (r_gate_cnt == r_gate - GATE_W'(1));
    assign w_win_last    = (r_win == c_win_w'(c_nwin - 1));
    assign w_cnt_next    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(w_edge);
    assign w_acc_next    = r_acc + c_acc_w'(w_cnt_next);
    assign w_next_sel    = f_first_set(r_mask, int'(r_ch) + 1);
    assign w_wrap_sel    = f_first_set(ch_mask, 0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start && (ch_mask != '0)) w_state_next = S_SETTLE;
            S_SETTLE: if (w_settle_done) w_state_next = S_GATE;
            S_GATE:   if (w_gate_last && w_win_last) w_state_next = S_OUT;
            S_OUT: begin
                if (result_ready) begin
                    if (w_next_sel[c_ch_w] || (cont && w_wrap_sel[c_ch_w])) w_state_next = S_SETTLE;
                    else                                                    w_state_next = S_IDLE;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
        if (!en) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prev       <= '0;
            r_mask       <= '0;
            r_gate       <= '0;
            r_gate_cnt   <= '0;
            r_ch         <= '0;
            r_settle_cnt <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_result     <= '0;
            r_result_ch  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!en) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && (ch_mask != '0)) begin
                            r_mask       <= ch_mask;
                            r_gate       <= w_gate_eff;
                            r_ch         <= w_wrap_sel[c_ch_w-1:0];
                            r_overflow   <= 1'b0;
                            r_settle_cnt <= '0;
                            r_acc        <= '0;
                            r_win        <= '0;
                            r_cnt        <= '0;
                            r_gate_cnt   <= '0;
                        end
                    end
                    S_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
                    S_GATE: begin
                        if (w_cnt_next == c_cnt_max) r_overflow <= 1'b1;
                        if (w_gate_last) begin
                            r_acc      <= w_acc_next;
                            r_cnt      <= '0;
                            r_gate_cnt <= '0;
                            r_win      <= r_win + 1'b1;
                            if (w_win_last) begin
                                r_result    <= CNT_W'(w_acc_next >> AVG_LOG2);
                                r_result_ch <= r_ch;
                            end
                        end else begin
                            r_cnt      <= w_cnt_next;
                            r_gate_cnt <= r_gate_cnt + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (result_ready) begin
                            if (w_next_sel[c_ch_w]) begin
                                r_ch <= w_next_sel[c_ch_w-1:0];
                            end else if (cont && w_wrap_sel[c_ch_w]) begin
                                // Wrap re-reads the live mask and gate length.
                                r_ch   <= w_wrap_sel[c_ch_w-1:0];
                                r_mask <= ch_mask;
                                r_gate <= w_gate_eff;
                            end
                            r_settle_cnt <= '0;
                            r_acc        <= '0;
                            r_win        <= '0;
                            r_cnt        <= '0;
                            r_gate_cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ro_en = '0;
        if (r_state != S_IDLE) ro_en[r_ch] = 1'b1;
    end

    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = (r_state == S_OUT);
    assign busy         = (r_state != S_IDLE);
    assign overflow     = r_overflow;

endmodule
`default_nettype wire
